// File: rtl/slice_sequencer_if.sv
// Valid/ready bundle for slice_sequencer:
// wide word in, OFFSET-bit slices out.
interface slice_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int OFFSET = 4
);
  localparam int N    = (WIDTH + OFFSET - 1) / OFFSET;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_msb_first;
  logic              out_valid;
  logic              out_ready;
  logic [OFFSET-1:0] out_data;
  logic [IDXW-1:0]   out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/slice_sequencer.sv
// Serialises a WIDTH-bit word into OFFSET-bit slices,
// LSB- or MSB-first per word, over valid/ready.
module slice_sequencer #(
  parameter int WIDTH  = 8,
  parameter int OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  slice_sequencer_if.slave  bus,
  output logic              busy
);
  localparam int N    = (WIDTH + OFFSET - 1) / OFFSET;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = N * OFFSET;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic [0:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] word_q;
  logic             dir_q;

  logic             send;
  logic [IDXW-1:0]  p;
  logic [PW-1:0]    pad;
  logic [OFFSET-1:0] slice;

  assign send = (state == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      word_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.in_valid) begin
            state  <= SEND;
            idx    <= '0;
            word_q <= bus.in_data;
            dir_q  <= bus.in_msb_first;
          end
        end
        (state == SEND): begin
          if (bus.out_ready) begin
            if (idx == LAST) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Zero-extend so a partial top slice reads 0 above WIDTH.
  assign pad   = PW'(word_q);
  assign p     = dir_q ? (LAST - idx) : idx;
  assign slice = pad[int'(p)*OFFSET +: OFFSET];

  assign bus.in_ready  = ~send;
  assign bus.out_valid = send;
  assign bus.out_data  = send ? slice : '0;
  assign bus.out_idx   = send ? idx : '0;
  assign bus.out_last  = send & (idx == LAST);
  assign busy          = send;
endmodule

// File: tb/tb_slice_sequencer.sv
// Randomised bench for slice_sequencer: three sizes
// (8/4, 10/4, 6/6) against an arithmetic slice model.
module tb_slice_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int W [3] = '{8, 10, 6};
  int O [3] = '{4, 4, 6};

  logic        iv [3];
  logic        im [3];
  logic        ordy [3];
  logic [15:0] id [3];
  logic        ir [3];
  logic        ov [3];
  logic        ol [3];
  logic        bz [3];
  logic [15:0] od [3];
  logic [3:0]  ox [3];

  int passed = 0;
  int total  = 0;

  slice_sequencer_if #(.WIDTH(8),  .OFFSET(4)) b0 ();
  slice_sequencer_if #(.WIDTH(10), .OFFSET(4)) b1 ();
  slice_sequencer_if #(.WIDTH(6),  .OFFSET(6)) b2 ();

  slice_sequencer #(.WIDTH(8), .OFFSET(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .busy(bz[0]));
  slice_sequencer #(.WIDTH(10), .OFFSET(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(bz[1]));
  slice_sequencer #(.WIDTH(6), .OFFSET(6)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .busy(bz[2]));

  assign b0.in_valid = iv[0];
  assign b0.in_msb_first = im[0];
  assign b0.out_ready = ordy[0];
  assign b0.in_data = id[0][7:0];
  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign ol[0] = b0.out_last;
  assign od[0] = 16'(b0.out_data);
  assign ox[0] = 4'(b0.out_idx);

  assign b1.in_valid = iv[1];
  assign b1.in_msb_first = im[1];
  assign b1.out_ready = ordy[1];
  assign b1.in_data = id[1][9:0];
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign ol[1] = b1.out_last;
  assign od[1] = 16'(b1.out_data);
  assign ox[1] = 4'(b1.out_idx);

  assign b2.in_valid = iv[2];
  assign b2.in_msb_first = im[2];
  assign b2.out_ready = ordy[2];
  assign b2.in_data = id[2][5:0];
  assign ir[2] = b2.in_ready;
  assign ov[2] = b2.out_valid;
  assign ol[2] = b2.out_last;
  assign od[2] = 16'(b2.out_data);
  assign ox[2] = 4'(b2.out_idx);

  function automatic int nslices(int u);
    return (W[u] + O[u] - 1) / O[u];
  endfunction

  // Slice k of a word: pick the physical chunk, shift, mask.
  function automatic logic [15:0] model(int u, logic [15:0] d,
                                        bit msb, int k);
    int n = nslices(u);
    int p = msb ? (n - 1 - k) : k;
    longint m = longint'(d) & ((64'd1 << W[u]) - 1);
    m = (m >> (p * O[u])) & ((64'd1 << O[u]) - 1);
    return 16'(m);
  endfunction

  task automatic send_word(int u, logic [15:0] d, bit msb,
                           int stall0, bit rnd);
    int n = nslices(u);
    int st;
    logic [15:0] e;
    total++;
    if (ir[u] !== 1'b1) $display("FAIL accept_ready u%0d got %b want 1", u, ir[u]);
    else passed++;
    iv[u] = 1'b1; id[u] = d; im[u] = msb; ordy[u] = 1'b0;
    @(negedge clk);
    iv[u] = 1'b0; id[u] = 16'($urandom); im[u] = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      st = (k == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
      e = model(u, d, msb, k);
      for (int s = 0; s <= st; s++) begin
        total++;
        if ({ov[u], ir[u], bz[u]} !== 3'b101)
          $display("FAIL send_flags u%0d k%0d got %b want 101", u, k, {ov[u], ir[u], bz[u]});
        else passed++;
        total++;
        if (od[u] !== e)
          $display("FAIL slice_data u%0d k%0d got %h want %h", u, k, od[u], e);
        else passed++;
        total++;
        if (ox[u] !== 4'(k))
          $display("FAIL slice_idx u%0d got %0d want %0d", u, ox[u], k);
        else passed++;
        total++;
        if (ol[u] !== (k == n - 1))
          $display("FAIL slice_last u%0d k%0d got %b want %b", u, k, ol[u], k == n - 1);
        else passed++;
        ordy[u] = (s == st);
        if (rnd) begin
          iv[u] = !(k == n - 1 && s == st) && ($urandom_range(0, 1) == 1);
          id[u] = 16'($urandom);
          im[u] = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    iv[u] = 1'b0; ordy[u] = 1'b0;
    total++;
    if ({ov[u], ir[u], bz[u], ol[u], od[u], ox[u]} !== {3'b010, 1'b0, 16'h0, 4'h0})
      $display("FAIL back_idle u%0d got v%b r%b b%b l%b d%h i%0d want idle zeros",
               u, ov[u], ir[u], bz[u], ol[u], od[u], ox[u]);
    else passed++;
  endtask

  task automatic check_reset_outs(string tag);
    for (int u = 0; u < 3; u++) begin
      total++;
      if ({ir[u], ov[u], bz[u], ol[u], od[u], ox[u]} !== {4'b1000, 16'h0, 4'h0})
        $display("FAIL %s u%0d got r%b v%b b%b l%b d%h i%0d want r1 rest 0",
                 tag, u, ir[u], ov[u], bz[u], ol[u], od[u], ox[u]);
      else passed++;
    end
  endtask

  task automatic test_reset;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'($urandom); im[u] = 1'($urandom);
      ordy[u] = 1'($urandom); id[u] = 16'($urandom);
    end
    repeat (2) @(negedge clk);
    check_reset_outs("reset_hold");
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outs("reset_idle");
    end
  endtask

  task automatic test_order;
    send_word(0, 16'hA5, 1'b0, 0, 1'b0);
    send_word(0, 16'hA5, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    send_word(0, 16'hA5, 1'b0, 3, 1'b0);
  endtask

  task automatic test_partial;
    send_word(1, 16'h2C7, 1'b0, 0, 1'b0);
    send_word(1, 16'h2C7, 1'b1, 0, 1'b0);
  endtask

  task automatic test_single;
    send_word(2, 16'h2B, 1'b0, 0, 1'b0);
    send_word(2, 16'h15, 1'b1, 2, 1'b0);
  endtask

  task automatic test_abort;
    iv[0] = 1'b1; id[0] = 16'hA5; im[0] = 1'b0; ordy[0] = 1'b0;
    @(negedge clk);
    id[0] = 16'h3C;
    @(negedge clk);
    total++;
    if ({ov[0], od[0], ox[0]} !== {1'b1, 16'h5, 4'h0})
      $display("FAIL interfere u0 got v%b d%h i%0d want v1 d5 i0", ov[0], od[0], ox[0]);
    else passed++;
    #2 rst_n = 1'b0;
    #1 check_reset_outs("abort_async");
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(0, 16'h3C, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      send_word(int'($urandom_range(0, 2)), 16'($urandom),
                1'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; im[u] = 1'b0; ordy[u] = 1'b0; id[u] = 16'h0;
    end
    #3;
    test_reset;
    test_order;
    test_backpressure;
    test_partial;
    test_single;
    test_abort;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
